// File: rtl/mouse_position_tracker_if.sv
// Packet-in / position-out bundle between the PS/2 transceiver, the tracker and its consumers.
// The packet side is driven by the transceiver; the position side is read by display/control logic.
interface mouse_position_tracker_if;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic [7:0] MOUSE_X;
    logic [7:0] MOUSE_Y;
    logic [2:0] BUTTONS;
    logic       L_CLICK;
    logic       POS_VALID;
    logic       PKT_DROPPED;

    modport master (
        output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
        input  MOUSE_X, MOUSE_Y, BUTTONS, L_CLICK, POS_VALID, PKT_DROPPED
    );

    modport slave (
        input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
        output MOUSE_X, MOUSE_Y, BUTTONS, L_CLICK, POS_VALID, PKT_DROPPED
    );
endinterface

// File: rtl/mouse_position_tracker.sv
// Integrates PS/2 mouse deltas into a clamped absolute cursor position with button/click reporting.
// One packet is processed at a time; a single-entry buffer holds a packet arriving mid-processing.
module mouse_position_tracker #(
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 60,
    parameter int Y_INVERT = 1
) (
    input logic                    CLK,
    input logic                    RESET,
    mouse_position_tracker_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CHECK, ADD, CLAMP, DONE} state_t;

    localparam logic signed [9:0] X_MAX_S = 10'(X_MAX);
    localparam logic signed [9:0] Y_MAX_S = 10'(Y_MAX);

    state_t state_reg, state_next;

    logic [7:0] cap_status_reg, cap_dx_reg, cap_dy_reg;
    logic       pending_reg;
    logic [7:0] work_status_reg, work_dx_reg, work_dy_reg;

    logic signed [9:0] sum_x_reg, sum_y_reg;
    logic signed [9:0] sum_x_next, sum_y_next;
    logic [7:0]        clamp_x_next, clamp_y_next;

    logic [7:0] x_reg, y_reg;
    logic [2:0] buttons_reg;
    logic       pos_valid_reg, l_click_reg;

    logic bad_pkt, overwrite;
    logic signed [9:0] dx_ext, dy_ext;

    function automatic logic [7:0] clamp(input logic signed [9:0] v, input logic signed [9:0] maxv);
        if (v < 10'sd0)
            return 8'd0;
        else if (v > maxv)
            return maxv[7:0];
        else
            return v[7:0];
    endfunction

    assign bad_pkt   = ~work_status_reg[3] | work_status_reg[6] | work_status_reg[7];
    // A second interrupt while a packet is already held always discards the held one.
    assign overwrite = bus.SEND_INTERRUPT & pending_reg;

    assign dx_ext = {work_status_reg[4], work_status_reg[4], work_dx_reg};
    assign dy_ext = {work_status_reg[5], work_status_reg[5], work_dy_reg};

    always_comb begin
        state_next   = state_reg;
        sum_x_next   = $signed({2'b00, x_reg}) + dx_ext;
        sum_y_next   = (Y_INVERT != 0) ? $signed({2'b00, y_reg}) - dy_ext
                                       : $signed({2'b00, y_reg}) + dy_ext;
        clamp_x_next = clamp(sum_x_reg, X_MAX_S);
        clamp_y_next = clamp(sum_y_reg, Y_MAX_S);
        case (state_reg)
            IDLE:    if (bus.SEND_INTERRUPT || pending_reg) state_next = CHECK;
            CHECK:   state_next = bad_pkt ? IDLE : ADD;
            ADD:     state_next = CLAMP;
            CLAMP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg       <= IDLE;
            cap_status_reg  <= '0;
            cap_dx_reg      <= '0;
            cap_dy_reg      <= '0;
            pending_reg     <= 1'b0;
            work_status_reg <= '0;
            work_dx_reg     <= '0;
            work_dy_reg     <= '0;
            sum_x_reg       <= '0;
            sum_y_reg       <= '0;
            x_reg           <= 8'(X_INIT);
            y_reg           <= 8'(Y_INIT);
            buttons_reg     <= '0;
            pos_valid_reg   <= 1'b0;
            l_click_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (bus.SEND_INTERRUPT) begin
                cap_status_reg <= bus.MOUSE_STATUS;
                cap_dx_reg     <= bus.MOUSE_DX;
                cap_dy_reg     <= bus.MOUSE_DY;
            end
            // In IDLE a same-cycle interrupt wins over the held packet.
            if (state_reg == IDLE) begin
                if (bus.SEND_INTERRUPT) begin
                    work_status_reg <= bus.MOUSE_STATUS;
                    work_dx_reg     <= bus.MOUSE_DX;
                    work_dy_reg     <= bus.MOUSE_DY;
                    pending_reg     <= 1'b0;
                end else if (pending_reg) begin
                    work_status_reg <= cap_status_reg;
                    work_dx_reg     <= cap_dx_reg;
                    work_dy_reg     <= cap_dy_reg;
                    pending_reg     <= 1'b0;
                end
            end else if (bus.SEND_INTERRUPT) begin
                pending_reg <= 1'b1;
            end
            if (state_reg == ADD) begin
                sum_x_reg <= sum_x_next;
                sum_y_reg <= sum_y_next;
            end
            pos_valid_reg <= (state_reg == CLAMP);
            l_click_reg   <= (state_reg == CLAMP) & work_status_reg[0] & ~buttons_reg[0];
            if (state_reg == CLAMP) begin
                x_reg       <= clamp_x_next;
                y_reg       <= clamp_y_next;
                buttons_reg <= work_status_reg[2:0];
            end
        end
    end

    assign bus.MOUSE_X     = x_reg;
    assign bus.MOUSE_Y     = y_reg;
    assign bus.BUTTONS     = buttons_reg;
    assign bus.POS_VALID   = pos_valid_reg;
    assign bus.L_CLICK     = l_click_reg;
    assign bus.PKT_DROPPED = ~RESET & (((state_reg == CHECK) & bad_pkt) | overwrite);

endmodule
